// File: rtl/multdiv.sv
// -----------------------------------------------------------------------------
// multdiv -- iterative 32-bit signed multiplier / divider.
//
// A start pulse latches both operands and the operation. The block then runs
// 32 single-bit iterations on the operand magnitudes: shift-add for multiply,
// restoring shift-subtract for divide. It applies the result sign and the
// exception flag on the edge that enters DONE.
//
// Ports
//   clock           in   rising-edge clock
//   ctrl_reset      in   asynchronous active-high reset
//   ctrl_MULT       in   one-cycle start pulse, signed multiply (wins over DIV)
//   ctrl_DIV        in   one-cycle start pulse, signed divide
//   data_operandA   in   multiplicand / dividend (sampled at start only)
//   data_operandB   in   multiplier / divisor   (sampled at start only)
//   data_result     out  low 32 bits of product, or truncated quotient
//   data_exception  out  product overflow, divide-by-zero or quotient overflow
//   data_resultRDY  out  one-cycle pulse while the result is valid
// -----------------------------------------------------------------------------
module multdiv (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's-complement magnitude; 0x80000000 maps to unsigned 2^31 unchanged.
  function automatic logic [31:0] f_mag(input logic [31:0] v);
    f_mag = v[31] ? (~v + 32'd1) : v;
  endfunction

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg;       // sign of the final result
  logic        r_div_zero;
  logic [31:0] r_m;         // multiplicand (MULT) or divisor (DIV) magnitude
  logic [31:0] r_acc;       // product high half (MULT) or partial remainder (DIV)
  logic [31:0] r_lo;        // multiplier / product low half, or dividend / quotient
  logic [31:0] r_result;
  logic        r_exception;
  logic        r_rdy;

  logic        w_start;
  logic [32:0] w_add;
  logic [31:0] w_shl;
  logic [32:0] w_diff;
  logic [31:0] w_acc_nxt;
  logic [31:0] w_lo_nxt;
  logic [63:0] w_prod;
  logic [31:0] w_signed;
  logic [31:0] w_fin_result;
  logic        w_fin_exc;

  assign w_start        = ctrl_MULT | ctrl_DIV;
  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = r_rdy;

  // One iteration of shift-add (MULT) or restoring shift-subtract (DIV).
  // In DIV the remainder is always below the divisor (<= 2^31), so its top bit
  // is zero and the shifted remainder fits in 32 bits.
  always_comb begin
    w_add  = {1'b0, r_acc} + {1'b0, (r_lo[0] ? r_m : 32'd0)};
    w_shl  = {r_acc[30:0], r_lo[31]};
    w_diff = {1'b0, w_shl} - {1'b0, r_m};
    w_acc_nxt = 32'd0;
    w_lo_nxt  = 32'd0;
    if (r_is_div) begin
      if (w_diff[32] == 1'b0) begin
        w_acc_nxt = w_diff[31:0];
        w_lo_nxt  = {r_lo[30:0], 1'b1};
      end else begin
        w_acc_nxt = w_shl;
        w_lo_nxt  = {r_lo[30:0], 1'b0};
      end
    end else begin
      w_acc_nxt = w_add[32:1];
      w_lo_nxt  = {w_add[0], r_lo[31:1]};
    end
  end

  // Final sign correction and exception flag, valid on the last iteration.
  always_comb begin
    w_prod       = {w_acc_nxt, w_lo_nxt};
    w_signed     = r_neg ? (~w_lo_nxt + 32'd1) : w_lo_nxt;
    w_fin_result = w_signed;
    w_fin_exc    = 1'b0;
    if (r_is_div) begin
      if (r_div_zero) begin
        w_fin_result = 32'd0;
        w_fin_exc    = 1'b1;
      end else begin
        // Only a positive quotient of 2^31 (0x80000000 / -1) can overflow.
        w_fin_result = w_signed;
        w_fin_exc    = ~r_neg & w_lo_nxt[31];
      end
    end else begin
      if (r_neg) begin
        w_fin_exc = (w_prod > 64'h0000_0000_8000_0000);
      end else begin
        w_fin_exc = (w_prod > 64'h0000_0000_7FFF_FFFF);
      end
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_is_div    <= 1'b0;
      r_neg       <= 1'b0;
      r_div_zero  <= 1'b0;
      r_m         <= 32'd0;
      r_acc       <= 32'd0;
      r_lo        <= 32'd0;
      r_result    <= 32'd0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
    end else if (w_start) begin
      // A start from any state restarts; an in-flight result is dropped.
      r_state    <= S_BUSY;
      r_cnt      <= 5'd0;
      r_is_div   <= ~ctrl_MULT;
      r_neg      <= data_operandA[31] ^ data_operandB[31];
      r_div_zero <= ~ctrl_MULT & (data_operandB == 32'd0);
      r_m        <= ctrl_MULT ? f_mag(data_operandA) : f_mag(data_operandB);
      r_lo       <= ctrl_MULT ? f_mag(data_operandB) : f_mag(data_operandA);
      r_acc      <= 32'd0;
      r_rdy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rdy <= 1'b0;
        end
        S_BUSY: begin
          r_acc <= w_acc_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state     <= S_DONE;
            r_result    <= w_fin_result;
            r_exception <= w_fin_exc;
            r_rdy       <= 1'b1;
          end else begin
            r_rdy <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_rdy   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv.sv
module tb_multdiv;

  logic        clock;
  logic        ctrl_reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  multdiv dut (
    .clock          (clock),
    .ctrl_reset     (ctrl_reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [31:0] res;
    logic        exc;
  } pend_t;

  pend_t       q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          n_exp_rdy = 0;
  int          n_act_rdy = 0;
  logic [31:0] held_res = 32'd0;
  logic        held_exc = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Behavioural reference: plain signed 64-bit arithmetic.
  task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e);
    longint p;
    if (is_mult) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else begin
      p = longint'($signed(a)) / longint'($signed(b));
      r = p[31:0];
      e = (p > 64'sd2147483647);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clock) begin
    logic exp_rdy;
    exp_rdy = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      held_res = q[0].res;
      held_exc = q[0].exc;
      void'(q.pop_front());
      exp_rdy = 1'b1;
      n_exp_rdy++;
    end
    if (data_resultRDY === 1'b1) n_act_rdy++;
    chk("rdy", {31'd0, data_resultRDY}, {31'd0, exp_rdy});
    chk("result", data_result, held_res);
    chk("exception", {31'd0, data_exception}, {31'd0, held_exc});
  end

  task automatic tick();
    @(posedge clock);
    #2;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom();
    data_operandB = $urandom();
  endtask

  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    pend_t       p;
    @(posedge clock);
    #2;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    if (!ctrl_reset && (m || d)) begin
      // Anything not yet delivered by the coming start edge is aborted.
      while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
      model(m, a, b, r, e);
      p.due = cyc + 33;
      p.res = r;
      p.exc = e;
      q.push_back(p);
    end
  endtask

  task automatic directed(input string nm, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee);
    start_op(m, d, a, b);
    repeat (32) tick();
    @(negedge clock);
    chk({nm, " rdy_early"}, {31'd0, data_resultRDY}, 32'd0);
    tick();
    @(negedge clock);
    chk({nm, " rdy"}, {31'd0, data_resultRDY}, 32'd1);
    chk({nm, " result"}, data_result, er);
    chk({nm, " exception"}, {31'd0, data_exception}, {31'd0, ee});
  endtask

  task automatic do_reset(input int hold);
    @(posedge clock);
    #2;
    ctrl_reset = 1'b1;
    ctrl_MULT  = 1'b1;   // start sampled under reset must be ignored
    q.delete();
    held_res = 32'd0;
    held_exc = 1'b0;
    #1;
    chk("rst result", data_result, 32'd0);
    chk("rst exception", {31'd0, data_exception}, 32'd0);
    chk("rst rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (hold) tick();
    @(posedge clock);
    #2;
    ctrl_reset = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h0000_0001;
      4, 5: begin
        v = 32'($urandom_range(0, 70000));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] r;
    logic        e;
    bit          m;
    bit          d;

    ctrl_reset    = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    #1;
    chk("init result", data_result, 32'd0);
    chk("init exception", {31'd0, data_exception}, 32'd0);
    chk("init rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (3) @(posedge clock);
    #2;
    ctrl_reset = 1'b0;

    // Pin the reference model with hand-computed values.
    model(1'b1, 32'd6, 32'd7, r, e);
    chk("model mul 6x7", {r[30:0], e}, {31'h2A, 1'b0});
    model(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, r, e);
    chk("model div ovf", {r[30:0], e}, {31'h0, 1'b1});
    chk("model div ovf msb", {31'd0, r[31]}, 32'd1);
    model(1'b0, 32'hFFFF_FFF9, 32'd2, r, e);
    chk("model div -7/2", r, 32'hFFFF_FFFD);
    model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, r, e);
    chk("model mul ovf", {31'd0, e}, 32'd1);

    // Directed cases with literal expectations.
    directed("mul 6x7",      1'b1, 1'b0, 32'd6,          32'd7,          32'h0000_002A, 1'b0);
    directed("mul -3x5",     1'b1, 1'b0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 1'b0);
    directed("mul 2^16sq",   1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000, 1'b1);
    directed("mul both",     1'b1, 1'b1, 32'd10,         32'd3,          32'h0000_001E, 1'b0);
    directed("mul min*-1",   1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1);
    directed("mul min*1",    1'b1, 1'b0, 32'h8000_0000,  32'd1,          32'h8000_0000, 1'b0);
    directed("div 100/-7",   1'b0, 1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2, 1'b0);
    directed("div 5/0",      1'b0, 1'b1, 32'd5,          32'd0,          32'h0000_0000, 1'b1);
    directed("div min/-1",   1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1);
    directed("div -3/7",     1'b0, 1'b1, 32'hFFFF_FFFD,  32'd7,          32'h0000_0000, 1'b0);
    directed("div min/2",    1'b0, 1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000, 1'b0);

    // Abort: MULT 3x3 replaced by DIV 9/3 ten cycles later.
    start_op(1'b1, 1'b0, 32'd3, 32'd3);
    repeat (9) tick();
    directed("abort div 9/3", 1'b0, 1'b1, 32'd9, 32'd3, 32'h0000_0003, 1'b0);

    // Reset in the middle of a MULT, then a fresh 2x2.
    start_op(1'b1, 1'b0, 32'h0001_2345, 32'h0000_0777);
    repeat (14) tick();
    do_reset(2);
    repeat (40) tick();
    directed("post-reset 2x2", 1'b1, 1'b0, 32'd2, 32'd2, 32'h0000_0004, 1'b0);

    // Randomized operations, with occasional aborts and back-to-back starts.
    for (int i = 0; i < 2000; i++) begin
      m = (i % 2 == 0);
      d = !m || ($urandom_range(0, 7) == 0);
      start_op(m, d, rnd_op(), rnd_op());
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 31)) tick();
      end else begin
        repeat ($urandom_range(32, 35)) tick();
      end
    end
    repeat (40) tick();

    chk("queue drained", 32'(q.size()), 32'd0);
    chk("rdy pulse count", 32'(n_act_rdy), 32'(n_exp_rdy));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
